// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle for the decode stage.
interface decode_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_DA, out_AA, out_BA;
    logic              out_RW, out_PS, out_MW, out_MB, out_MA, out_CS;
    logic [1:0]        out_MD, out_BS;
    logic [3:0]        out_FS;
    logic              out_illegal;
    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_DA, out_AA, out_BA, out_RW, out_PS, out_MW,
               out_MB, out_MA, out_CS, out_MD, out_BS, out_FS, out_illegal
    );
    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_DA, out_AA, out_BA, out_RW, out_PS, out_MW,
               out_MB, out_MA, out_CS, out_MD, out_BS, out_FS, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered valid/ready instruction decoder with load-use stall and flush.
module decode_stage #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    decode_if.slave          bus,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [6:0]        op;
    logic [ADDR_W-1:0] da, aa, ba;
    logic              rw, ps, mw, mb, ma, cs, ill;
    logic [1:0]        md, bs;
    logic [3:0]        fs;
    logic              hazard, accept;

    assign op = bus.in_inst[INST_W-1 -: 7];
    assign da = bus.in_inst[INST_W-8 -: ADDR_W];
    assign aa = bus.in_inst[INST_W-8-ADDR_W -: ADDR_W];
    assign ba = bus.in_inst[INST_W-8-2*ADDR_W -: ADDR_W];

    always_comb begin
        {rw, ps, mw, mb, ma, cs, ill} = '0;
        md = 2'b00;
        bs = 2'b00;
        fs = op[3:0];
        case (op)
            7'h40, 7'h02, 7'h05, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E: rw = 1'b1;
            7'h22, 7'h25: {rw, mb, cs} = 3'b111;
            7'h28, 7'h29, 7'h2A, 7'h42, 7'h45: {rw, mb} = 2'b11;
            7'h10: begin rw = 1'b1; md = 2'b01; end
            7'h20: mw = 1'b1;
            7'h70: bs = 2'b10;
            7'h65: begin rw = 1'b1; md = 2'b10; end
            7'h60: begin bs = 2'b01; {mb, cs} = 2'b11; end
            7'h4C: begin bs = 2'b01; {ps, mb, cs} = 3'b111; fs = 4'b0000; end
            7'h68: begin bs = 2'b11; {mb, cs} = 2'b11; end
            7'h30: begin bs = 2'b11; {rw, mb, ma, cs} = 4'b1111; end
            7'h00: ;
            default: begin fs = 4'b0000; ill = 1'b1; end
        endcase
    end

    // Load-use: the held LD writes a register the incoming instruction reads.
    assign hazard = bus.in_valid & bus.out_valid & bus.out_RW & (bus.out_MD == 2'b01) &
                    ((!ma & (bus.out_DA == aa)) | (!mb & (bus.out_DA == ba)));
    assign bus.in_ready = !rst & !flush & !hazard & (!bus.out_valid | bus.out_ready);
    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            {bus.out_DA, bus.out_AA, bus.out_BA} <= '0;
            {bus.out_RW, bus.out_PS, bus.out_MW, bus.out_MB, bus.out_MA, bus.out_CS} <= '0;
            {bus.out_MD, bus.out_BS, bus.out_FS, bus.out_illegal} <= '0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            {bus.out_DA, bus.out_AA, bus.out_BA} <= {da, aa, ba};
            {bus.out_RW, bus.out_PS, bus.out_MW, bus.out_MB, bus.out_MA, bus.out_CS} <=
                {rw, ps, mw, mb, ma, cs};
            {bus.out_MD, bus.out_BS, bus.out_FS, bus.out_illegal} <= {md, bs, fs, ill};
        end else if (bus.out_valid & bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (hazard & !flush & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage, run with a 4-bit stall counter.
module tb_decode_stage;
    typedef struct packed {
        logic [4:0] da, aa, ba;
        logic       rw;
        logic [1:0] md, bs;
        logic       ps, mw;
        logic [3:0] fs;
        logic       mb, ma, cs, ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] stall_cnt;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    exp_t       act;

    always #5 clk = ~clk;

    decode_if #(.INST_W(32), .ADDR_W(5)) bus ();

    decode_stage #(.INST_W(32), .ADDR_W(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave), .stall_cnt(stall_cnt)
    );

    assign act = {bus.out_DA, bus.out_AA, bus.out_BA, bus.out_RW, bus.out_MD, bus.out_BS,
                  bus.out_PS, bus.out_MW, bus.out_FS, bus.out_MB, bus.out_MA, bus.out_CS,
                  bus.out_illegal};

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d, a, b);
        return {op, d, a, b, 10'h0};
    endfunction

    function automatic exp_t model(input logic [31:0] inst);
        exp_t       e;
        logic [6:0] op;
        op = inst[31:25];
        e = '0;
        e.da = inst[24:20];
        e.aa = inst[19:15];
        e.ba = inst[14:10];
        e.fs = op[3:0];
        if (op inside {7'h40, 7'h02, 7'h05, [7'h08:7'h0E]}) e.rw = 1;
        else if (op inside {7'h22, 7'h25}) begin e.rw = 1; e.mb = 1; e.cs = 1; end
        else if (op inside {7'h28, 7'h29, 7'h2A, 7'h42, 7'h45}) begin e.rw = 1; e.mb = 1; end
        else if (op == 7'h10) begin e.rw = 1; e.md = 2'b01; end
        else if (op == 7'h20) e.mw = 1;
        else if (op == 7'h70) e.bs = 2'b10;
        else if (op == 7'h65) begin e.rw = 1; e.md = 2'b10; end
        else if (op == 7'h60) begin e.bs = 2'b01; e.mb = 1; e.cs = 1; end
        else if (op == 7'h4C) begin e.bs = 2'b01; e.ps = 1; e.mb = 1; e.cs = 1; e.fs = 0; end
        else if (op == 7'h68) begin e.bs = 2'b11; e.mb = 1; e.cs = 1; end
        else if (op == 7'h30) begin e.rw = 1; e.bs = 2'b11; e.mb = 1; e.ma = 1; e.cs = 1; end
        else if (op != 7'h00) begin e.fs = 0; e.ill = 1; end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got %h, expected none", act);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL sb_output: got %h, expected %h", act, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_inst));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst);
        int k = 0;
        bus.in_inst = inst;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && k < 8) begin
            k++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst = mk(7'h02, 3, 1, 2);
        bus.out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_fields: got %h, expected 0", act); end
        n_checks++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt); end
        step();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_inst = mk(7'h02, 3, 1, 2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready0: got %b, expected 1", bus.in_ready); end
        step();
        bus.in_inst = mk(7'h22, 5, 6, 7);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_RW !== 1'b1 || bus.out_FS !== 4'b0010 || bus.out_DA !== 5'd3 || bus.out_MB !== 1'b0)
            begin n_fail++; $display("FAIL stream_add: got %h, expected valid ADD rw=1 fs=2 da=3", act); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready1: got %b, expected 1", bus.in_ready); end
        step();
        bus.in_inst = mk(7'h20, 0, 8, 9);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_RW, bus.out_MB, bus.out_CS} !== 3'b111 || bus.out_DA !== 5'd5)
            begin n_fail++; $display("FAIL stream_adi: got %h, expected rw=mb=cs=1 da=5", act); end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_MW !== 1'b1 || bus.out_RW !== 1'b0)
            begin n_fail++; $display("FAIL stream_st: got %h, expected mw=1 rw=0", act); end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b, expected 0", bus.out_valid); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(mk(7'h05, 7, 1, 1));
        bus.in_inst = mk(7'h09, 8, 2, 2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, expected 0", bus.in_ready); end
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_DA !== 5'd7 || bus.out_FS !== 4'd5)
                begin n_fail++; $display("FAIL bp_hold: got %h, expected held da=7 fs=5", act); end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_hazard();
        bus.out_ready = 1'b1;
        send(mk(7'h10, 4, 0, 0));
        bus.in_inst = mk(7'h02, 1, 4, 0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_stall: got %b, expected 0", bus.in_ready); end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_fail++; $display("FAIL hz_bubble: got valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_AA !== 5'd4 || bus.out_DA !== 5'd1)
            begin n_fail++; $display("FAIL hz_follow: got %h, expected ADD aa=4", act); end
        n_checks++;
        if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL hz_cnt1: got %0d, expected 1", stall_cnt); end
        step();
        send(mk(7'h10, 4, 0, 0));
        bus.in_inst = mk(7'h22, 2, 4, 4);
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_adi: got %b, expected 0", bus.in_ready); end
        step();
        step();
        bus.in_valid = 1'b0;
        send(mk(7'h10, 4, 0, 0));
        bus.in_inst = mk(7'h02, 1, 5, 6);
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_indep: got %b, expected 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL hz_cnt2: got %0d, expected 2", stall_cnt); end
        step();
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        send(mk(7'h7F, 9, 10, 11));
        @(negedge clk);
        n_checks++;
        if (bus.out_illegal !== 1'b1 || bus.out_FS !== 4'd0 || bus.out_DA !== 5'd9 || bus.out_BA !== 5'd11 ||
            {bus.out_RW, bus.out_PS, bus.out_MW, bus.out_MB, bus.out_MA, bus.out_CS, bus.out_MD, bus.out_BS} !== '0)
            begin n_fail++; $display("FAIL illegal_7f: got %h, expected ill=1 control 0 da=9", act); end
        step();
        send(mk(7'h4C, 0, 3, 0));
        @(negedge clk);
        n_checks++;
        if (bus.out_BS !== 2'b01 || {bus.out_PS, bus.out_MB, bus.out_CS} !== 3'b111 || bus.out_FS !== 4'd0 || bus.out_illegal !== 1'b0)
            begin n_fail++; $display("FAIL bnz: got %h, expected bs=01 ps=mb=cs=1 fs=0", act); end
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        send(mk(7'h02, 3, 1, 2));
        bus.in_inst = mk(7'h20, 0, 1, 2);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b, expected 0", bus.in_ready); end
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, expected 0", bus.out_valid); end
        n_checks++;
        if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL flush_cnt: got %0d, expected 2", stall_cnt); end
        step();
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        bus.out_ready = 1'b0;
        send(mk(7'h10, 4, 0, 0));
        bus.in_inst = mk(7'h02, 1, 0, 4);
        bus.in_valid = 1'b1;
        repeat (19) step();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d, expected 15", stall_cnt); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready: got %b, expected 0", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [12] = '{7'h02, 7'h10, 7'h22, 7'h20, 7'h30, 7'h4C, 7'h65, 7'h7F, 7'h00, 7'h45, 7'h68, 7'h10};
        for (int i = 0; i < 300; i++) begin
            bus.in_inst = mk(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)),
                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_hazard();
        test_illegal();
        test_flush();
        test_saturate();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage for the pipelined RISC core. Sits between fetch and execute: accepts one instruction word per valid/ready handshake, decodes it into register addresses and the control word (RW, MD, BS, PS, MW, FS, MB, MA, CS), and holds the result in an output pipeline register. Generalises the combinational decoder with parametrised field widths, an illegal-opcode flag, load-use hazard stalling, flush, and a saturating stall counter.

## Interface
- INST_W, 32, instruction width; must satisfy INST_W >= 7 + 3*ADDR_W
- ADDR_W, 5, register address width
- CNT_W, 16, stall counter width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard held and incoming instruction (branch redirect)
- in_valid  input  1  fetch presents in_inst
- in_ready  output  1  stage accepts in_inst this cycle (combinational)
- in_inst  input  INST_W  instruction word
- out_valid  output  1  output register holds a decoded instruction
- out_ready  input  1  execute consumes output this cycle
- out_DA / out_AA / out_BA  output  ADDR_W each  destination / A / B register addresses
- out_RW, out_PS, out_MW, out_MB, out_MA, out_CS  output  1 each  control bits
- out_MD, out_BS  output  2 each  control fields
- out_FS  output  4  function select
- out_illegal  output  1  held opcode not in decode table
- stall_cnt  output  CNT_W  load-use stall cycles since reset

## Operation
- Fields: opcode = in_inst[INST_W-1 -: 7]; DA, AA, BA = the next three ADDR_W-bit fields below it, in that order; remaining low bits ignored.
- Decode defaults: all control 0, FS = opcode[3:0], illegal = 0. Overrides (hex opcode):
  - RW=1: 40, 02, 05, 08, 09, 0A, 0B, 0C, 0D, 0E
  - RW,MB,CS=1: 22, 25
  - RW,MB=1: 28, 29, 2A, 42, 45
  - 10 (LD): RW=1, MD=01; 20 (ST): MW=1; 70 (JMR): BS=10; 65 (SLT): RW=1, MD=10
  - 60 (BZ): BS=01, MB=CS=1; 4C (BNZ): BS=01, PS=MB=CS=1, FS=0000
  - 68 (JMP): BS=11, MB=CS=1; 30 (JML): RW=1, BS=11, MB=MA=CS=1
  - 00 (NOP): all control 0, legal
  - any other opcode: all control 0 including FS, illegal=1; address fields pass through.
- Hazard (combinational): in_valid & out_valid & out_RW & out_MD==01 & ((decoded MA==0 & out_DA==AA) | (decoded MB==0 & out_DA==BA)). Register 0 is not special.
- in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready: output register loads decoded fields, out_valid<=1.
- out_valid & out_ready without accept: out_valid<=0; fields hold last values.
- Hazard consequence: LD drains, register empties for one cycle (bubble), dependent instruction accepted the following cycle.
- flush: out_valid<=0; no accept that cycle; stall_cnt unaffected.
- stall_cnt increments each cycle with hazard & !flush & !rst; saturates at 2^CNT_W-1.

## Timing
- Priority: rst > flush > accept > drain.
- Reset: out_valid=0, all out_* fields 0, out_illegal=0, stall_cnt=0; in_ready=0 while rst high.
- Latency: in_inst accepted at edge N appears on outputs after edge N; out_valid high from then.
- Throughput: one instruction/cycle when out_ready held high and no hazard.
- out_* stable while out_valid & !out_ready.
- Simultaneous drain and accept: new instruction replaces old, out_valid stays 1.
- Reset or flush mid-stall: pending instruction is not accepted; fetch must re-present.

## Test plan
- Reset then stream ADD(02, DA=3, AA=1, BA=2), ADI(22), ST(20) with out_ready=1 -> one per cycle, ADD: RW=1, FS=0010; ADI: RW=MB=CS=1; ST: MW=1; 1-cycle latency.
- out_ready=0 for 3 cycles with valid held -> in_ready=0, outputs stable, no loss or duplication.
- LD (10, DA=4) then ADD (AA=4) -> in_ready=0 one cycle, out_valid=0 one cycle after LD drains, ADD follows; stall_cnt=1. ADI with AA=4 also stalls; ADD with AA=5, BA=6 does not.
- Opcode 7F -> out_illegal=1, all control 0, FS=0000; BNZ (4C) -> BS=01, PS=MB=CS=1, FS=0000.
- flush asserted with valid held instruction and in_valid=1 -> next cycle out_valid=0, nothing accepted.
- Force 2^CNT_W+3 hazard cycles with CNT_W=4 -> stall_cnt saturates at 15.
